// File: rtl/mips_pkg.sv
// Shared definitions for the CPU run controller: FSM state encoding and
// the default instruction word that terminates a run.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_FINISH = 3'd4
    } run_state_t;

    // MIPS "syscall" encoding.
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_000C;

endpackage

// File: rtl/sat_counter.sv
// Up counter with synchronous clear that sticks at all-ones instead of
// wrapping, so long runs never report a misleadingly small count.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for a simple core: holds it in reset after start, then runs
// freely or single-steps until a halt instruction or the cycle budget ends it.
import mips_pkg::*;

module cpu_run_ctrl #(
    parameter int          CYC_W      = 32,
    parameter int          RST_CYCLES = 4,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic [CYC_W-1:0] i_max_cycles,
    input  logic [31:0]      i_instr,
    input  logic             i_instr_valid,
    input  logic [31:0]      i_pc,
    output logic             o_core_rst,
    output logic             o_core_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CYC_W-1:0] o_cycle_cnt,
    output logic [CYC_W-1:0] o_retire_cnt,
    output logic [31:0]      o_halt_pc
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    run_state_t        r_state;
    run_state_t        w_next_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_core_rst;
    logic              r_core_en;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;
    logic [31:0]       r_halt_pc;

    logic              w_start_run;
    logic              w_halt;
    logic              w_budget;
    logic              w_retire;
    logic [CYC_W-1:0]  w_cycle_cnt;
    logic [CYC_W-1:0]  w_retire_cnt;

    // core_en is only ever high in RUN/STEP, so it doubles as "enabled cycle".
    assign w_start_run = i_start && ((r_state == ST_IDLE) || (r_state == ST_FINISH));
    assign w_retire    = r_core_en && i_instr_valid;
    assign w_halt      = w_retire && (i_instr == HALT_INSTR);
    assign w_budget    = r_core_en && (i_max_cycles != '0) &&
                         (w_cycle_cnt == (i_max_cycles - CYC_W'(1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_FINISH: begin
                if (i_start) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = i_step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN, ST_STEP: begin
                if (w_halt || w_budget) begin
                    w_next_state = ST_FINISH;
                end else begin
                    w_next_state = i_step_mode ? ST_STEP : ST_RUN;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_cnt <= '0;
            r_core_rst <= 1'b1;
            r_core_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_halt_pc  <= '0;
        end else begin
            r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + 1'b1 : '0;
            r_core_rst <= (w_next_state == ST_IDLE) || (w_next_state == ST_HOLD);
            r_core_en  <= (w_next_state == ST_RUN) ||
                          ((w_next_state == ST_STEP) && i_step);
            r_busy     <= (w_next_state == ST_HOLD) || (w_next_state == ST_RUN) ||
                          (w_next_state == ST_STEP);
            if (w_start_run) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
                r_halt_pc <= '0;
            end else begin
                if (w_halt) begin
                    r_done    <= 1'b1;
                    r_halt_pc <= i_pc;
                end
                if (w_budget) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    sat_counter #(.W(CYC_W)) u_cycle_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_start_run),
        .i_inc (r_core_en),
        .o_q   (w_cycle_cnt)
    );

    sat_counter #(.W(CYC_W)) u_retire_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_start_run),
        .i_inc (w_retire),
        .o_q   (w_retire_cnt)
    );

    assign o_core_rst   = r_core_rst;
    assign o_core_en    = r_core_en;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_timeout    = r_timeout;
    assign o_cycle_cnt  = w_cycle_cnt;
    assign o_retire_cnt = w_retire_cnt;
    assign o_halt_pc    = r_halt_pc;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized
// runs scored against a per-cycle model of halt/budget/saturation rules.
module tb_cpu_run_ctrl;

    localparam int          CYC_W      = 8;
    localparam int          RST_CYCLES = 4;
    localparam int          DEPTH      = 512;
    localparam logic [31:0] HALT       = 32'h0000_000C;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_start = 1'b0;
    logic             i_step_mode = 1'b0;
    logic             i_step = 1'b0;
    logic [CYC_W-1:0] i_max_cycles = '0;
    logic [31:0]      i_instr = '0;
    logic             i_instr_valid = 1'b0;
    logic [31:0]      i_pc = '0;
    logic             o_core_rst, o_core_en, o_busy, o_done, o_timeout;
    logic [CYC_W-1:0] o_cycle_cnt, o_retire_cnt;
    logic [31:0]      o_halt_pc;

    logic             stimValid [DEPTH];
    logic [31:0]      stimInstr [DEPTH];
    logic [31:0]      stimPc    [DEPTH];

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.CYC_W(CYC_W), .RST_CYCLES(RST_CYCLES), .HALT_INSTR(HALT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (i_start),
        .i_step_mode  (i_step_mode),
        .i_step       (i_step),
        .i_max_cycles (i_max_cycles),
        .i_instr      (i_instr),
        .i_instr_valid(i_instr_valid),
        .i_pc         (i_pc),
        .o_core_rst   (o_core_rst),
        .o_core_en    (o_core_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_cycle_cnt  (o_cycle_cnt),
        .o_retire_cnt (o_retire_cnt),
        .o_halt_pc    (o_halt_pc)
    );

    // Random non-halt stream; density is the percentage of valid cycles.
    task automatic fillNoHalt(input int density);
        for (int j = 0; j < DEPTH; j++) begin
            stimValid[j] = ($urandom_range(0, 99) < density);
            stimInstr[j] = $urandom | 32'h0000_1000;
            stimPc[j]    = 32'h0000_0004 * j;
        end
    endtask

    task automatic startRun();
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        repeat (RST_CYCLES) @(negedge clk);
    endtask

    // Feeds the stream one entry per enabled cycle until the run ends.
    task automatic runStream(output int cycles);
        cycles = 0;
        while (o_busy && cycles < DEPTH) begin
            i_instr_valid = stimValid[cycles];
            i_instr       = stimInstr[cycles];
            i_pc          = stimPc[cycles];
            @(negedge clk);
            cycles++;
        end
        i_instr_valid = 1'b0;
        i_instr       = '0;
        i_pc          = '0;
        checkCount++;
        if (o_busy !== 1'b0)
            $display("[TB] FAIL run_budget: still busy after %0d cycles, required idle", cycles);
        else
            passCount++;
    endtask

    // Reference: walk the stream, counting enabled cycles and retirements,
    // stopping on the first halt word or when the budget-th cycle completes.
    task automatic modelRun(input int maxc, output int expCyc, output int expRet,
                            output int expLen, output logic expDone,
                            output logic expTo, output logic [31:0] expPc);
        int cyc, ret;
        cyc = 0; ret = 0; expLen = DEPTH;
        expDone = 1'b0; expTo = 1'b0; expPc = '0;
        for (int j = 0; j < DEPTH; j++) begin
            cyc++;
            if (stimValid[j]) ret++;
            if (stimValid[j] && stimInstr[j] == HALT) begin
                expDone = 1'b1;
                expPc   = stimPc[j];
            end
            if (maxc != 0 && cyc == maxc) expTo = 1'b1;
            if (expDone || expTo) begin
                expLen = j + 1;
                break;
            end
        end
        expCyc = (cyc > 255) ? 255 : cyc;
        expRet = (ret > 255) ? 255 : ret;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkCount++;
        if ({o_core_rst, o_core_en, o_busy, o_done, o_timeout} !== 5'b10000)
            $display("[TB] FAIL reset_flags: got %b required 10000",
                     {o_core_rst, o_core_en, o_busy, o_done, o_timeout});
        else passCount++;
        checkCount++;
        if (o_cycle_cnt !== 8'd0 || o_retire_cnt !== 8'd0 || o_halt_pc !== 32'd0)
            $display("[TB] FAIL reset_counts: got %0d/%0d/%0h required 0/0/0",
                     o_cycle_cnt, o_retire_cnt, o_halt_pc);
        else passCount++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++;
        if ({o_core_rst, o_core_en, o_busy} !== 3'b100)
            $display("[TB] FAIL idle_core_rst: got %b required 100",
                     {o_core_rst, o_core_en, o_busy});
        else passCount++;
    endtask

    task automatic test_start_hold();
        i_step_mode  = 1'b0;
        i_max_cycles = '0;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        for (int k = 0; k < RST_CYCLES; k++) begin
            checkCount++;
            if ({o_core_rst, o_core_en, o_busy} !== 3'b101)
                $display("[TB] FAIL hold_cycle%0d: got %b required 101", k,
                         {o_core_rst, o_core_en, o_busy});
            else passCount++;
            @(negedge clk);
        end
        checkCount++;
        if ({o_core_rst, o_core_en, o_busy} !== 3'b011)
            $display("[TB] FAIL run_entry: got %b required 011",
                     {o_core_rst, o_core_en, o_busy});
        else passCount++;
        i_instr_valid = 1'b1; i_instr = HALT; i_pc = 32'h40;
        @(negedge clk);
        i_instr_valid = 1'b0; i_instr = '0;
        checkCount++;
        if (o_done !== 1'b1 || o_cycle_cnt !== 8'd1 || o_retire_cnt !== 8'd1)
            $display("[TB] FAIL first_halt: got done=%b cyc=%0d ret=%0d required 1/1/1",
                     o_done, o_cycle_cnt, o_retire_cnt);
        else passCount++;
    endtask

    task automatic test_halt_directed();
        int cycles;
        fillNoHalt(0);
        for (int j = 0; j < 10; j++) stimValid[j] = 1'b1;
        stimValid[10] = 1'b1; stimInstr[10] = HALT; stimPc[10] = 32'h28;
        i_max_cycles = '0;
        startRun();
        runStream(cycles);
        checkCount++;
        if (o_done !== 1'b1 || o_timeout !== 1'b0 || o_core_en !== 1'b0)
            $display("[TB] FAIL halt_flags: got done=%b to=%b en=%b required 1/0/0",
                     o_done, o_timeout, o_core_en);
        else passCount++;
        checkCount++;
        if (o_retire_cnt !== 8'd11 || o_cycle_cnt !== 8'd11 || o_halt_pc !== 32'h28)
            $display("[TB] FAIL halt_counts: got ret=%0d cyc=%0d pc=%0h required 11/11/28",
                     o_retire_cnt, o_cycle_cnt, o_halt_pc);
        else passCount++;
        i_instr_valid = 1'b1; i_instr = 32'h1234_5678;
        repeat (3) @(negedge clk);
        i_instr_valid = 1'b0;
        checkCount++;
        if (o_retire_cnt !== 8'd11 || o_cycle_cnt !== 8'd11 || o_done !== 1'b1)
            $display("[TB] FAIL finish_frozen: got ret=%0d cyc=%0d done=%b required 11/11/1",
                     o_retire_cnt, o_cycle_cnt, o_done);
        else passCount++;
    endtask

    task automatic test_timeout();
        int cycles;
        fillNoHalt(70);
        i_max_cycles = 8'd20;
        startRun();
        runStream(cycles);
        checkCount++;
        if (o_timeout !== 1'b1 || o_done !== 1'b0 || o_cycle_cnt !== 8'd20 || cycles != 20)
            $display("[TB] FAIL timeout20: got to=%b done=%b cyc=%0d len=%0d required 1/0/20/20",
                     o_timeout, o_done, o_cycle_cnt, cycles);
        else passCount++;
    endtask

    task automatic test_step();
        int enCount = 0;
        i_step_mode  = 1'b1;
        i_max_cycles = '0;
        startRun();
        checkCount++;
        if (o_core_en !== 1'b0 || o_busy !== 1'b1)
            $display("[TB] FAIL step_entry: got en=%b busy=%b required 0/1", o_core_en, o_busy);
        else passCount++;
        for (int p = 0; p < 3; p++) begin
            i_step = 1'b1;
            @(negedge clk);
            i_step = 1'b0;
            if (o_core_en) enCount++;
            repeat (3) begin
                @(negedge clk);
                if (o_core_en) enCount++;
            end
        end
        checkCount++;
        if (enCount != 3 || o_cycle_cnt !== 8'd3)
            $display("[TB] FAIL step_three: got en_cycles=%0d cyc=%0d required 3/3",
                     enCount, o_cycle_cnt);
        else passCount++;
        i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        @(negedge clk);
        checkCount++;
        if (o_core_rst !== 1'b0 || o_busy !== 1'b1 || o_cycle_cnt !== 8'd3)
            $display("[TB] FAIL start_ignored: got rst=%b busy=%b cyc=%0d required 0/1/3",
                     o_core_rst, o_busy, o_cycle_cnt);
        else passCount++;
        i_step_mode = 1'b0;
        @(negedge clk);
        checkCount++;
        if (o_core_en !== 1'b1)
            $display("[TB] FAIL step_to_run: got en=%b required 1", o_core_en);
        else passCount++;
        i_instr_valid = 1'b1; i_instr = HALT; i_pc = 32'h100;
        @(negedge clk);
        i_instr_valid = 1'b0; i_instr = '0;
        checkCount++;
        if (o_done !== 1'b1 || o_cycle_cnt !== 8'd4 || o_retire_cnt !== 8'd1 || o_halt_pc !== 32'h100)
            $display("[TB] FAIL step_halt: got done=%b cyc=%0d ret=%0d pc=%0h required 1/4/1/100",
                     o_done, o_cycle_cnt, o_retire_cnt, o_halt_pc);
        else passCount++;
    endtask

    task automatic test_both();
        int cycles;
        int m;
        m = $urandom_range(6, 30);
        fillNoHalt(60);
        stimValid[m-1] = 1'b1; stimInstr[m-1] = HALT; stimPc[m-1] = 32'h200 + m;
        i_max_cycles = m[CYC_W-1:0];
        startRun();
        runStream(cycles);
        checkCount++;
        if (o_done !== 1'b1 || o_timeout !== 1'b1 || o_cycle_cnt !== m[CYC_W-1:0] ||
            o_halt_pc !== (32'h200 + m))
            $display("[TB] FAIL halt_and_timeout: got done=%b to=%b cyc=%0d pc=%0h required 1/1/%0d/%0h",
                     o_done, o_timeout, o_cycle_cnt, o_halt_pc, m, 32'h200 + m);
        else passCount++;
    endtask

    task automatic test_random();
        int cycles, maxc, expCyc, expRet, expLen, hpos;
        logic expDone, expTo;
        logic [31:0] expPc;
        for (int it = 0; it < 10; it++) begin
            maxc = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 60);
            fillNoHalt($urandom_range(30, 100));
            if (maxc == 0 || $urandom_range(0, 1) == 1) begin
                hpos = $urandom_range(0, 80);
                stimValid[hpos] = 1'b1; stimInstr[hpos] = HALT;
            end
            modelRun(maxc, expCyc, expRet, expLen, expDone, expTo, expPc);
            i_max_cycles = maxc[CYC_W-1:0];
            startRun();
            checkCount++;
            if (o_done !== 1'b0 || o_timeout !== 1'b0 || o_cycle_cnt !== 8'd0 || o_halt_pc !== 32'd0)
                $display("[TB] FAIL restart_clear%0d: got done=%b to=%b cyc=%0d pc=%0h required 0/0/0/0",
                         it, o_done, o_timeout, o_cycle_cnt, o_halt_pc);
            else passCount++;
            runStream(cycles);
            checkCount++;
            if (o_cycle_cnt !== expCyc[CYC_W-1:0] || o_retire_cnt !== expRet[CYC_W-1:0] || cycles != expLen)
                $display("[TB] FAIL rand_counts%0d: got cyc=%0d ret=%0d len=%0d required %0d/%0d/%0d",
                         it, o_cycle_cnt, o_retire_cnt, cycles, expCyc, expRet, expLen);
            else passCount++;
            checkCount++;
            if (o_done !== expDone || o_timeout !== expTo || o_halt_pc !== expPc)
                $display("[TB] FAIL rand_flags%0d: got done=%b to=%b pc=%0h required %b/%b/%0h",
                         it, o_done, o_timeout, o_halt_pc, expDone, expTo, expPc);
            else passCount++;
        end
    endtask

    task automatic test_saturate();
        int cycles;
        fillNoHalt(100);
        stimInstr[300] = HALT; stimPc[300] = 32'h4B0;
        i_max_cycles = '0;
        startRun();
        runStream(cycles);
        checkCount++;
        if (o_cycle_cnt !== 8'hFF || o_retire_cnt !== 8'hFF || o_done !== 1'b1 || cycles != 301)
            $display("[TB] FAIL saturate: got cyc=%0d ret=%0d done=%b len=%0d required 255/255/1/301",
                     o_cycle_cnt, o_retire_cnt, o_done, cycles);
        else passCount++;
    endtask

    task automatic test_midrun_reset();
        int cycles;
        fillNoHalt(100);
        i_max_cycles = '0;
        startRun();
        for (int k = 0; k < 7; k++) begin
            i_instr_valid = stimValid[k]; i_instr = stimInstr[k]; i_pc = stimPc[k];
            @(negedge clk);
        end
        i_instr_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if ({o_core_rst, o_core_en, o_busy, o_done, o_timeout} !== 5'b10000 ||
            o_cycle_cnt !== 8'd0 || o_retire_cnt !== 8'd0 || o_halt_pc !== 32'd0)
            $display("[TB] FAIL async_abort: got flags=%b cyc=%0d ret=%0d pc=%0h required 10000/0/0/0",
                     {o_core_rst, o_core_en, o_busy, o_done, o_timeout},
                     o_cycle_cnt, o_retire_cnt, o_halt_pc);
        else passCount++;
        @(negedge clk) rst = 1'b0;
        fillNoHalt(100);
        stimInstr[5] = HALT; stimPc[5] = 32'h14;
        startRun();
        runStream(cycles);
        checkCount++;
        if (o_cycle_cnt !== 8'd6 || o_retire_cnt !== 8'd6 || o_done !== 1'b1 || o_halt_pc !== 32'h14)
            $display("[TB] FAIL rerun_after_reset: got cyc=%0d ret=%0d done=%b pc=%0h required 6/6/1/14",
                     o_cycle_cnt, o_retire_cnt, o_done, o_halt_pc);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_start_hold();
        test_halt_directed();
        test_timeout();
        test_step();
        test_both();
        test_random();
        test_saturate();
        test_midrun_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
